vram_rect_fill: RTL and testbench
=================================

# vram_rect_fill

Rectangle-fill engine that writes a solid rrr_ggg_bb colour into the pixel RAM's write port, one pixel per clock, in row-major order. It is the writer side of the 640x480 frame buffer that the VGA scan-out logic reads. It uses the same row/col address layout: 9-bit row (512 lines), 10-bit col (1024 pixels). The rectangle is clipped to the visible 640x480 area, and a start/busy/done handshake connects it to the game CPU's I/O logic.

## Interface
- H_VIS, 640, visible columns; writes with col >= H_VIS are suppressed
- V_VIS, 480, visible rows; writes with row >= V_VIS are suppressed
- vga_clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- x0  in  10  left column of rectangle
- y0  in  9  top row of rectangle
- w  in  10  width in pixels (0 = empty)
- h  in  9  height in lines (0 = empty)
- color  in  8  fill pixel, rrr_ggg_bb
- stall  in  1  write port unavailable this cycle; freezes the engine
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the fill completes
- wr_row_addr  out  9  pixel RAM row address
- wr_col_addr  out  10  pixel RAM col address
- wr_data  out  8  pixel RAM write data
- wrn  out  1  write strobe, active low

## Operation
- States: IDLE, CLIP, FILL, DONE.
- IDLE
  - On start=1, latch x0, y0, w, h and color, then go to CLIP.
  - start is ignored in every other state.
- CLIP (one cycle), 11-bit arithmetic:
  - x_end = min(x0+w, H_VIS)
  - y_end = min(y0+h, V_VIS)
  - Empty if w==0, h==0, x0>=H_VIS or y0>=V_VIS.
  - Empty: go to DONE.
  - Otherwise: load col=x0, row=y0 and go to FILL.
- FILL, each cycle with stall=0:
  - Register wrn=0, wr_row_addr=row, wr_col_addr=col, wr_data=color.
  - Advance: col+1. If col+1==x_end, then col=x0 and row+1.
  - When row+1==y_end on that wrap, go to DONE.
- FILL with stall=1:
  - Register wrn=1.
  - Counters and the address/data outputs hold their values.
  - There are no partial or duplicate writes.
- DONE (one cycle): done=1, busy=0 next, return to IDLE.
- The latched colour and geometry are not affected by input changes after start is accepted.
- Total write strobes = (x_end-x0)*(y_end-y0), each pixel exactly once, order row-major.

## Timing
- Reset: state=IDLE.
  - Output reset values: busy=0, done=0, wrn=1, wr_row_addr=0, wr_col_addr=0, wr_data=0.
  - Reset applies on the next vga_clk edge, including mid-fill.
  - Pixels already written remain in RAM; no further writes are issued.
- Start accepted at edge N: busy=1 after edge N.
- First write: wrn=0 with the first address after edge N+1, i.e. 2-cycle latency from start to first write.
- Throughput: 1 pixel per non-stalled cycle.
  - A non-stalled rectangle of P pixels puts wrn=0 on cycles N+1 .. N+P.
  - done=1 after edge N+P+1, with busy=0 that same cycle.
- Empty rectangle: done=1 after edge N+1 (CLIP → DONE); wrn stays 1.
- stall is sampled at the edge that would issue a write.
  - stall=1 during the final pixel delays done by the stall length.
- start=1 held continuously: the block re-accepts in IDLE the cycle after DONE, giving back-to-back fills with a minimum 1 idle cycle.
- wrn is the only qualifier. wr_* values while wrn=1 are don't-care for the RAM, but must hold stable during stalls.

## Test plan
- Basic fill:
  - Stimulus: x0=10, y0=5, w=2, h=2, color=0xE0, stall=0.
  - Required: writes (row,col) = (5,10), (5,11), (6,10), (6,11) on 4 consecutive cycles starting 2 cycles after start, data 0xE0.
  - done 1 cycle after the last write; busy high throughout.
- Clipping:
  - Stimulus: x0=638, w=5, y0=478, h=4.
  - Required: exactly 4 writes, (478,638), (478,639), (479,638), (479,639).
  - No col>=640 or row>=480 is ever presented.
- Empty cases:
  - Stimulus: w=0; then x0=700.
  - Required: no wrn=0; done pulse 2 cycles after start in each case.
- Stall:
  - Stimulus: 3x1 fill at (0,0) with stall=1 for 3 cycles after the second write.
  - Required: exactly 3 writes, addresses held during the stall, done delayed by 3 cycles.
- Reset mid-fill and ignored start:
  - Stimulus: pulse start during busy with new geometry; later assert rst during a 100x100 fill.
  - Required: the second start does not alter the first fill's writes.
  - After rst: wrn=1, busy=0, done=0 next cycle; a new start then fills normally.
- Back-to-back:
  - Stimulus: hold start high for two 1x1 fills.
  - Required: second write exactly 3 cycles after the first done pulse; no pixel is written twice.

Source files
------------

// File: rtl/vram_rect_fill.sv
// vram_rect_fill
// Rectangle-fill engine for the 640x480 pixel RAM write port. It writes one
// rrr_ggg_bb pixel per clock in row-major order and clips the rectangle to
// the visible area. A start/busy/done handshake connects it to the CPU's I/O logic.
//
// Ports:
//   vga_clk      single clock for all logic
//   rst          synchronous, active-high reset
//   start        fill request, only looked at while idle
//   x0, y0       top-left corner (col 10 bits, row 9 bits)
//   w, h         width / height in pixels, 0 means empty
//   color        fill pixel value, rrr_ggg_bb
//   stall        write port unavailable this cycle, freezes the engine
//   busy         high while a fill is being processed
//   done         one-cycle pulse when the fill completes
//   wr_row_addr  pixel RAM row address
//   wr_col_addr  pixel RAM col address
//   wr_data      pixel RAM write data
//   wrn          write strobe, active low

module vram_rect_fill #(
  parameter logic [10:0] H_VIS = 11'd640,
  parameter logic [10:0] V_VIS = 11'd480
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [9:0] w,
  input  logic [8:0] h,
  input  logic [7:0] color,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic [8:0] wr_row_addr,
  output logic [9:0] wr_col_addr,
  output logic [7:0] wr_data,
  output logic       wrn
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [9:0]  x0_q;
  logic [9:0]  w_q;
  logic [8:0]  y0_q;
  logic [8:0]  h_q;
  logic [7:0]  color_q;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        fin;

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        empty;
  logic        col_last;
  logic        row_last;
  logic        issue;

  // Clipping bounds from the latched geometry. The sums are 11 bits wide,
  // so x0+w and y0+h cannot wrap before they are clamped.
  always_comb begin
    x_sum    = {1'b0, x0_q} + {1'b0, w_q};
    y_sum    = {2'b00, y0_q} + {2'b00, h_q};
    x_end    = (x_sum < H_VIS) ? x_sum : H_VIS;
    y_end    = (y_sum < V_VIS) ? y_sum : V_VIS;
    empty    = (w_q == 10'd0) || (h_q == 9'd0) ||
               ({1'b0, x0_q} >= H_VIS) || ({2'b00, y0_q} >= V_VIS);
    col_last = ({1'b0, col} + 11'd1) == x_end;
    row_last = ({2'b00, row} + 11'd1) == y_end;
  end

  // Next-state and handshake logic.
  // The first pixel is issued from CLIP, which gives the two-cycle latency
  // from start to the first write. FILL stays one more cycle after the final
  // write (fin set) so that done follows the last strobe by exactly one cycle.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLIP;
      end
      CLIP: begin
        busy = 1'b1;
        if (empty) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
          issue      = !stall;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (fin) state_next = DONE;
        else     issue      = !stall;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge vga_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Geometry latch, pixel counters and the registered write port.
  // When a cycle issues no write, wrn is raised and the counters and the
  // address/data outputs hold their values. A stalled pixel is therefore
  // retried later, and no pixel is written twice.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      x0_q        <= '0;
      w_q         <= '0;
      y0_q        <= '0;
      h_q         <= '0;
      color_q     <= '0;
      col         <= '0;
      row         <= '0;
      fin         <= 1'b0;
      wr_row_addr <= '0;
      wr_col_addr <= '0;
      wr_data     <= '0;
      wrn         <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        x0_q    <= x0;
        w_q     <= w;
        y0_q    <= y0;
        h_q     <= h;
        color_q <= color;
        col     <= x0;
        row     <= y0;
        fin     <= 1'b0;
      end
      if (issue) begin
        wrn         <= 1'b0;
        wr_row_addr <= row;
        wr_col_addr <= col;
        wr_data     <= color_q;
        if (col_last) begin
          col <= x0_q;
          row <= row + 9'd1;
          if (row_last) fin <= 1'b1;
        end else begin
          col <= col + 10'd1;
        end
      end else begin
        wrn <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// tb_vram_rect_fill
// Self-checking bench for vram_rect_fill. Each expected pixel write
// (row, col, data, cycle) is pushed to a scoreboard queue when a fill is
// started. A monitor pops and compares an entry on every wrn=0 cycle.
// A table of rectangles covers the basic, clipped and empty cases.
// Separate sequences cover stall, reset mid-fill, an ignored start and
// back-to-back fills.

module tb_vram_rect_fill;

  logic       vga_clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [9:0] w;
  logic [8:0] h;
  logic [7:0] color;
  logic       stall;
  logic       busy;
  logic       done;
  logic [8:0] wr_row_addr;
  logic [9:0] wr_col_addr;
  logic [7:0] wr_data;
  logic       wrn;

  typedef struct {
    int row;
    int col;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] w;
    logic [8:0] h;
    logic [7:0] color;
    int         expWrites;
    int         expLat;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;
  int writeCnt = 0;

  vram_rect_fill dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .color      (color),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .wr_row_addr(wr_row_addr),
    .wr_col_addr(wr_col_addr),
    .wr_data    (wr_data),
    .wrn        (wrn)
  );

  // 10 ns clock
  always #5 vga_clk = ~vga_clk;

  // Cycle counter: holds the index of the most recent rising edge
  initial begin : edgeCounter
    forever begin
      @(posedge vga_clk);
      cycleCnt = cycleCnt + 1;
    end
  end

  // Write monitor: each strobe must match the head of the scoreboard,
  // including the edge on which it was registered
  initial begin : writeMonitor
    wr_t e;
    forever begin
      @(negedge vga_clk);
      if (wrn === 1'b0) begin
        writeCnt = writeCnt + 1;
        checks   = checks + 1;
        if (sb.size() == 0) begin
          failures = failures + 1;
          $display("[TB] FAIL unexpected_write: got (%0d,%0d) data=%0h at cycle %0d, required no write",
                   wr_row_addr, wr_col_addr, wr_data, cycleCnt);
        end else begin
          e = sb.pop_front();
          if (int'(wr_row_addr) != e.row || int'(wr_col_addr) != e.col ||
              int'(wr_data) != e.data || cycleCnt != e.cyc) begin
            failures = failures + 1;
            $display("[TB] FAIL pixel_write: got (%0d,%0d) data=%0h cycle %0d, required (%0d,%0d) data=%0h cycle %0d",
                     wr_row_addr, wr_col_addr, wr_data, cycleCnt, e.row, e.col, e.data, e.cyc);
          end
        end
      end
    end
  end

  // Global watchdog so the bench can never hang
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Drive a fill request, let it be accepted on the next edge (N), and
  // queue the clipped pixels in row-major order at cycles N+1, N+2, ...
  task automatic applyStimulus(input vec_t v, output int startEdge);
    int xEnd;
    int yEnd;
    int idx;
    @(posedge vga_clk); #1;
    x0    = v.x0;
    y0    = v.y0;
    w     = v.w;
    h     = v.h;
    color = v.color;
    start = 1'b1;
    @(posedge vga_clk); #1;
    start     = 1'b0;
    startEdge = cycleCnt;
    xEnd = int'(v.x0) + int'(v.w);
    if (xEnd > 640) xEnd = 640;
    yEnd = int'(v.y0) + int'(v.h);
    if (yEnd > 480) yEnd = 480;
    idx = 0;
    for (int r = int'(v.y0); r < yEnd; r++) begin
      for (int c = int'(v.x0); c < xEnd; c++) begin
        sb.push_back('{r, c, int'(v.color), startEdge + 1 + idx});
        idx++;
      end
    end
  endtask

  // Wait (bounded) for done and check its latency, busy and the pulse width
  task automatic waitDone(input string name, input int startEdge, input int expLat);
    bit seen;
    bit busyOk;
    int lat;
    seen   = 1'b0;
    busyOk = 1'b1;
    lat    = 0;
    checkOutput({name, "_busy_after_start"}, int'(busy), 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge vga_clk); #1;
      lat = cycleCnt - startEdge;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
    end
    if (!seen) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("[TB] FAIL %s_done_timeout: got no done in 3000 cycles, required done at +%0d", name, expLat);
    end else begin
      checkOutput({name, "_done_latency"}, lat, expLat);
      checkOutput({name, "_busy_at_done"}, int'(busy), 0);
    end
    checkOutput({name, "_busy_throughout"}, int'(busyOk), 1);
    @(posedge vga_clk); #1;
    checkOutput({name, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic runVector(input string name, input vec_t v);
    int n;
    int w0;
    w0 = writeCnt;
    applyStimulus(v, n);
    waitDone(name, n, v.expLat);
    checkOutput({name, "_write_count"}, writeCnt - w0, v.expWrites);
    checkOutput({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin : main
    int   n;
    int   w0;
    int   expReset;
    vec_t v;

    // x0, y0, w, h, color, expected writes, expected done latency
    vecs[0] = '{10'd10,   9'd5,   10'd2,    9'd2,   8'hE0, 4,   5};
    vecs[1] = '{10'd638,  9'd478, 10'd5,    9'd4,   8'h1F, 4,   5};
    vecs[2] = '{10'd20,   9'd20,  10'd0,    9'd3,   8'hFF, 0,   1};
    vecs[3] = '{10'd700,  9'd0,   10'd10,   9'd10,  8'hFF, 0,   1};
    vecs[4] = '{10'd0,    9'd0,   10'd5,    9'd0,   8'hFF, 0,   1};
    vecs[5] = '{10'd0,    9'd480, 10'd5,    9'd5,   8'hFF, 0,   1};
    vecs[6] = '{10'd639,  9'd479, 10'd1,    9'd1,   8'h5A, 1,   2};
    vecs[7] = '{10'd630,  9'd470, 10'd1023, 9'd511, 8'hC3, 100, 101};
    vecs[8] = '{10'd0,    9'd0,   10'd3,    9'd2,   8'hAA, 6,   7};

    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    x0    = '0;
    y0    = '0;
    w     = '0;
    h     = '0;
    color = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_wrn", int'(wrn), 1);
    checkOutput("reset_row", int'(wr_row_addr), 0);
    checkOutput("reset_col", int'(wr_col_addr), 0);
    checkOutput("reset_data", int'(wr_data), 0);
    rst = 1'b0;

    $display("[TB] table-driven rectangles");
    for (int i = 0; i < 9; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // 3x1 fill with stall held for the three edges after the second write
    $display("[TB] stall sequence");
    v  = '{10'd0, 9'd0, 10'd3, 9'd1, 8'h55, 3, 7};
    w0 = writeCnt;
    applyStimulus(v, n);
    sb[2].cyc = sb[2].cyc + 3;
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      checkOutput($sformatf("stall_wrn_%0d", i), int'(wrn), 1);
      checkOutput($sformatf("stall_col_hold_%0d", i), int'(wr_col_addr), 1);
      checkOutput($sformatf("stall_row_hold_%0d", i), int'(wr_row_addr), 0);
    end
    stall = 1'b0;
    waitDone("stall", n, v.expLat);
    checkOutput("stall_write_count", writeCnt - w0, 3);
    checkOutput("stall_sb_empty", sb.size(), 0);

    // 100x100 fill: a second start while busy must be ignored, then reset mid-fill
    $display("[TB] ignored start and reset mid-fill");
    v  = '{10'd0, 9'd0, 10'd100, 9'd100, 8'h92, 0, 0};
    w0 = writeCnt;
    applyStimulus(v, n);
    repeat (3) @(posedge vga_clk);
    #1;
    x0    = 10'd50;
    y0    = 9'd50;
    w     = 10'd1;
    h     = 9'd1;
    color = 8'h01;
    start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
    repeat (150) @(posedge vga_clk);
    #1;
    expReset = cycleCnt - n;
    rst = 1'b1;
    @(posedge vga_clk); #1;
    checkOutput("rst_wrn", int'(wrn), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_writes_before", writeCnt - w0, expReset);
    rst = 1'b0;
    @(posedge vga_clk); #1;
    checkOutput("rst_no_more_writes", writeCnt - w0, expReset);
    checkOutput("rst_idle_busy", int'(busy), 0);
    sb.delete();
    runVector("post_reset", vecs[8]);

    // start held high: two 1x1 fills. The geometry changes after the first
    // acceptance, so the second fill must use the new values while the
    // first one keeps its latched values
    $display("[TB] back-to-back fills");
    w0 = writeCnt;
    @(posedge vga_clk); #1;
    x0    = 10'd3;
    y0    = 9'd4;
    w     = 10'd1;
    h     = 9'd1;
    color = 8'h1C;
    start = 1'b1;
    @(posedge vga_clk); #1;
    n     = cycleCnt;
    x0    = 10'd7;
    color = 8'h03;
    sb.push_back('{4, 3, 8'h1C, n + 1});
    sb.push_back('{4, 7, 8'h03, n + 5});
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    checkOutput("b2b_done1", int'(done), 1);
    @(posedge vga_clk); #1;
    checkOutput("b2b_idle_gap", int'(done | busy), 0);
    @(posedge vga_clk); #1;
    checkOutput("b2b_busy2", int'(busy), 1);
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    checkOutput("b2b_done2", int'(done), 1);
    start = 1'b0;
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    checkOutput("b2b_final_busy", int'(busy), 0);
    checkOutput("b2b_write_count", writeCnt - w0, 2);
    checkOutput("b2b_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
